// File: rtl/detector_emulator_if.sv
// Bundle of control inputs and status outputs of the detector emulator.
// The scenario side (or a bench) uses master; the emulator uses slave.
interface detector_emulator_if #(
  parameter int unsigned PROLONG_W = 24,
  parameter int unsigned CNT_W     = 16
);
  logic                 enable;
  logic                 trigger_in;
  logic [PROLONG_W-1:0] prolong_cycles;
  logic                 clear_counters;
  logic                 detector_ready;
  logic                 busy;
  logic [1:0]           state;
  logic [CNT_W-1:0]     trigger_count;
  logic [CNT_W-1:0]     short_count;
  logic [CNT_W-1:0]     overrun_count;

  modport master (
    output enable, trigger_in, prolong_cycles, clear_counters,
    input  detector_ready, busy, state, trigger_count, short_count, overrun_count
  );

  modport slave (
    input  enable, trigger_in, prolong_cycles, clear_counters,
    output detector_ready, busy, state, trigger_count, short_count, overrun_count
  );
endinterface

// File: rtl/detector_emulator.sv
// Detector emulator: responder end of the trigger/detector_ready handshake.
// Qualifies trigger pulses by length, holds detector_ready low for a latched
// prolong time and keeps saturating statistics of accepted, short and
// overrun triggers.
module detector_emulator #(
  parameter int unsigned TRIG_MIN_LEN = 20,
  parameter int unsigned PROLONG_W    = 24,
  parameter int unsigned CNT_W        = 16
) (
  input  logic               clock,
  input  logic               reset_signal,
  detector_emulator_if.slave det
);

  localparam int unsigned HIGH_W = (TRIG_MIN_LEN < 2) ? 1 : $clog2(TRIG_MIN_LEN + 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_QUALIFY  = 2'd1,
    S_BUSY     = 2'd2,
    S_WAIT_LOW = 2'd3
  } state_e;

  state_e               state_q,     state_d;
  logic                 ready_q,     ready_d;
  logic                 busy_q,      busy_d;
  logic                 trig_prev_q, trig_prev_d;
  logic                 armed_q,     armed_d;
  logic [HIGH_W-1:0]    high_cnt_q,  high_cnt_d;
  logic [PROLONG_W-1:0] busy_cnt_q,  busy_cnt_d;
  logic [CNT_W-1:0]     trig_cnt_q,  trig_cnt_d;
  logic [CNT_W-1:0]     short_cnt_q, short_cnt_d;
  logic [CNT_W-1:0]     over_cnt_q,  over_cnt_d;

  logic                 rise;
  logic                 accept;
  logic                 inc_trig;
  logic                 inc_short;
  logic                 inc_over;
  logic [HIGH_W-1:0]    high_nxt;
  logic [PROLONG_W-1:0] prolong_eff;

  // Next-state logic: trigger qualification, busy timing and statistics.
  always_comb begin
    state_d     = state_q;
    ready_d     = ready_q;
    busy_d      = busy_q;
    high_cnt_d  = high_cnt_q;
    busy_cnt_d  = busy_cnt_q;
    trig_cnt_d  = trig_cnt_q;
    short_cnt_d = short_cnt_q;
    over_cnt_d  = over_cnt_q;
    accept      = 1'b0;
    inc_short   = 1'b0;
    inc_over    = 1'b0;

    // armed_q stays low after reset until a low sample is seen, so a trigger
    // held high across reset release is not mistaken for a rising edge.
    trig_prev_d = det.trigger_in;
    armed_d     = armed_q | ~det.trigger_in;
    rise        = det.trigger_in & ~trig_prev_q & armed_q;
    high_nxt    = high_cnt_q + HIGH_W'(1);
    prolong_eff = (det.prolong_cycles == '0) ? PROLONG_W'(1) : det.prolong_cycles;

    unique case (state_q)
      S_IDLE: begin
        if (rise && det.enable) begin
          if (TRIG_MIN_LEN <= 1) begin
            accept = 1'b1;
          end else begin
            state_d    = S_QUALIFY;
            high_cnt_d = HIGH_W'(1);
          end
        end
      end
      S_QUALIFY: begin
        if (!det.enable) begin
          state_d = S_IDLE;
        end else if (det.trigger_in) begin
          if (high_nxt == HIGH_W'(TRIG_MIN_LEN)) begin
            accept = 1'b1;
          end else begin
            high_cnt_d = high_nxt;
          end
        end else begin
          inc_short = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_BUSY: begin
        inc_over = rise;
        if (busy_cnt_q == PROLONG_W'(1)) begin
          ready_d = 1'b1;
          busy_d  = 1'b0;
          state_d = det.trigger_in ? S_WAIT_LOW : S_IDLE;
        end else begin
          busy_cnt_d = busy_cnt_q - PROLONG_W'(1);
        end
      end
      S_WAIT_LOW: begin
        if (!det.trigger_in) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // The busy counter holds the remaining low clocks, including the current one.
    if (accept) begin
      state_d    = S_BUSY;
      ready_d    = 1'b0;
      busy_d     = 1'b1;
      busy_cnt_d = prolong_eff;
    end
    inc_trig = accept;

    if (det.clear_counters) begin
      trig_cnt_d  = '0;
      short_cnt_d = '0;
      over_cnt_d  = '0;
    end else begin
      if (inc_trig  && (trig_cnt_q  != '1)) trig_cnt_d  = trig_cnt_q  + CNT_W'(1);
      if (inc_short && (short_cnt_q != '1)) short_cnt_d = short_cnt_q + CNT_W'(1);
      if (inc_over  && (over_cnt_q  != '1)) over_cnt_d  = over_cnt_q  + CNT_W'(1);
    end
  end

  // State and output registers; reset returns to ready/idle with cleared stats.
  always_ff @(posedge clock or negedge reset_signal) begin
    if (!reset_signal) begin
      state_q     <= S_IDLE;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      trig_prev_q <= 1'b0;
      armed_q     <= 1'b0;
      high_cnt_q  <= '0;
      busy_cnt_q  <= '0;
      trig_cnt_q  <= '0;
      short_cnt_q <= '0;
      over_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      trig_prev_q <= trig_prev_d;
      armed_q     <= armed_d;
      high_cnt_q  <= high_cnt_d;
      busy_cnt_q  <= busy_cnt_d;
      trig_cnt_q  <= trig_cnt_d;
      short_cnt_q <= short_cnt_d;
      over_cnt_q  <= over_cnt_d;
    end
  end

  assign det.detector_ready = ready_q;
  assign det.busy           = busy_q;
  assign det.state          = state_q;
  assign det.trigger_count  = trig_cnt_q;
  assign det.short_count    = short_cnt_q;
  assign det.overrun_count  = over_cnt_q;

endmodule
